// File: rtl/place_issue_ctrl.sv
// Slot-cadenced round-robin issue scheduler sharing one placement core between two requesters.
// Optional strike halt is enabled by defining PLACE_CTRL_STRIKE_STOP_EN.
module place_issue_ctrl #(
    parameter int          SLOT_CYCLES  = 4,
    parameter int          CORE_LATENCY = 8,
    parameter logic [3:0]  STRIKE_LIMIT = 4'd15
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           req0_valid_i,
    input  logic                           req1_valid_i,
    output logic                           req0_ready_o,
    output logic                           req1_ready_o,
    input  logic [4:0]                     req0_height_i,
    input  logic [4:0]                     req0_width_i,
    input  logic [4:0]                     req1_height_i,
    input  logic [4:0]                     req1_width_i,
    output logic [4:0]                     core_height_o,
    output logic [4:0]                     core_width_o,
    output logic                           core_issue_o,
    output logic [$clog2(SLOT_CYCLES)-1:0] core_phase_o,
    input  logic [7:0]                     core_index_x_i,
    input  logic [7:0]                     core_index_y_i,
    input  logic [3:0]                     core_strike_i,
    output logic                           rsp_valid_o,
    output logic                           rsp_id_o,
    output logic [7:0]                     rsp_index_x_o,
    output logic [7:0]                     rsp_index_y_o,
    output logic [3:0]                     strike_o,
    output logic                           halt_o
);
    localparam int PW = $clog2(SLOT_CYCLES);

    logic [PW-1:0]           phase_q;
    logic                    slot_end;
    logic                    last_grant_q;
    logic                    grant;
    logic                    accept;
    logic                    issue;
    logic                    halt_q;
    logic [4:0]              sel_height;
    logic [4:0]              sel_width;
    logic [CORE_LATENCY-1:0] tag_valid_q;
    logic [CORE_LATENCY-1:0] tag_id_q;

    assign slot_end = (phase_q == PW'(SLOT_CYCLES - 1));

    // A lone valid port wins outright; a tie goes to the port not granted last.
    always_comb begin
        grant = ~last_grant_q;
        if (req0_valid_i && !req1_valid_i) begin
            grant = 1'b0;
        end else if (!req0_valid_i && req1_valid_i) begin
            grant = 1'b1;
        end
    end

    assign req0_ready_o = slot_end & ~grant & req0_valid_i & ~halt_q;
    assign req1_ready_o = slot_end &  grant & req1_valid_i & ~halt_q;
    assign accept       = req0_ready_o | req1_ready_o;
    assign sel_height   = grant ? req1_height_i : req0_height_i;
    assign sel_width    = grant ? req1_width_i  : req0_width_i;
    // Zero-size requests are consumed but travel as bubbles with no tag.
    assign issue        = accept & (sel_height != 5'd0) & (sel_width != 5'd0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            phase_q       <= '0;
            last_grant_q  <= 1'b1;
            core_height_o <= '0;
            core_width_o  <= '0;
            core_issue_o  <= 1'b0;
        end else begin
            core_issue_o <= 1'b0;
            if (slot_end) begin
                phase_q       <= '0;
                core_issue_o  <= issue;
                core_height_o <= issue ? sel_height : 5'd0;
                core_width_o  <= issue ? sel_width  : 5'd0;
                if (accept) begin
                    last_grant_q <= grant;
                end
            end else begin
                phase_q <= phase_q + PW'(1);
            end
        end
    end

    // Tag entering stage 0 at the issue edge exits CORE_LATENCY edges later.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tag_valid_q   <= '0;
            tag_id_q      <= '0;
            rsp_valid_o   <= 1'b0;
            rsp_id_o      <= 1'b0;
            rsp_index_x_o <= '0;
            rsp_index_y_o <= '0;
            strike_o      <= '0;
        end else begin
            tag_valid_q[0] <= slot_end & issue;
            tag_id_q[0]    <= grant;
            for (int i = 1; i < CORE_LATENCY; i++) begin
                tag_valid_q[i] <= tag_valid_q[i-1];
                tag_id_q[i]    <= tag_id_q[i-1];
            end
            rsp_valid_o <= tag_valid_q[CORE_LATENCY-1];
            if (tag_valid_q[CORE_LATENCY-1]) begin
                rsp_id_o      <= tag_id_q[CORE_LATENCY-1];
                rsp_index_x_o <= core_index_x_i;
                rsp_index_y_o <= core_index_y_i;
            end
            strike_o <= core_strike_i;
        end
    end

`ifdef PLACE_CTRL_STRIKE_STOP_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            halt_q <= 1'b0;
        end else if (core_strike_i >= STRIKE_LIMIT) begin
            halt_q <= 1'b1;
        end
    end
`else
    logic unused_strike_limit;
    assign unused_strike_limit = ^STRIKE_LIMIT;
    assign halt_q              = 1'b0;
`endif

    assign core_phase_o = phase_q;
    assign halt_o       = halt_q;

endmodule
